// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// The fetch entry stores the PC at XLEN_DEFAULT width.
package fetch_pkg;

    localparam int XLEN_DEFAULT = 64;
    localparam logic [31:0] RV_NOP = 32'h00000013;

    typedef struct packed {
        logic [XLEN_DEFAULT-1:0] pc;
        logic [31:0]             instr;
    } fetch_entry_t;

    function automatic logic [XLEN_DEFAULT-1:0] pc_plus4(input logic [XLEN_DEFAULT-1:0] pc);
        return pc + XLEN_DEFAULT'(4);
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetch entries.
// Flush clears the FIFO and takes priority over push and pop. DEPTH must be a power of two.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int  DEPTH = 2,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush,
    input  logic               push,
    input  logic               pop,
    input  fetch_entry_t       wdata,
    output fetch_entry_t       rdata,
    output logic [CNT_W-1:0]   count,
    output logic               full,
    output logic               empty
);

    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("fetch_fifo: DEPTH must be a power of two and at least 2");
    end

    fetch_entry_t     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    // A push into a full FIFO is accepted only when the head leaves in the same cycle.
    assign do_push = push & (!full | pop);
    assign do_pop  = pop & !empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            unique case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && !flush && do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, imem addressing, fetch buffer and redirect flush.
// Optional macro FETCH_STATS_EN adds saturating fetch/redirect/stall counters.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter int              XLEN       = XLEN_DEFAULT,
    parameter logic [XLEN-1:0] RESET_PC   = '0,
    parameter int              FIFO_DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    output logic [XLEN-3:0]  imem_addr,
    input  logic [31:0]      imem_instr,
    input  logic             redirect_valid,
    input  logic [XLEN-1:0]  redirect_pc,
    output logic             id_valid,
    input  logic             id_ready,
    output logic [XLEN-1:0]  id_pc,
    output logic [XLEN-1:0]  id_pc_plus4,
    output logic [31:0]      id_instr
`ifdef FETCH_STATS_EN
    ,
    output logic [31:0]      stat_fetched,
    output logic [31:0]      stat_redirects,
    output logic [31:0]      stat_stall_cycles
`endif
);

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    logic [XLEN-1:0]  pc;
    logic             push;
    logic             pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CNT_W-1:0] fifo_count;
    fetch_entry_t     fifo_wdata;
    fetch_entry_t     fifo_rdata;
    logic [XLEN-1:0]  head_pc;

    assign imem_addr = pc[XLEN-1:2];
    assign id_valid  = !fifo_empty;
    assign pop       = id_valid & id_ready;
    // Redirect cancels this cycle's fetch; the target is fetched the next cycle.
    assign push      = !redirect_valid & (!fifo_full | pop);

    assign fifo_wdata.pc    = XLEN_DEFAULT'(pc);
    assign fifo_wdata.instr = imem_instr;

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .flush (redirect_valid),
        .push  (push),
        .pop   (pop),
        .wdata (fifo_wdata),
        .rdata (fifo_rdata),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            pc <= RESET_PC;
        end else if (redirect_valid) begin
            pc <= {redirect_pc[XLEN-1:2], 2'b00};
        end else if (push) begin
            pc <= pc + XLEN'(4);
        end
    end

    assign head_pc     = XLEN'(fifo_rdata.pc);
    assign id_pc       = id_valid ? head_pc : '0;
    assign id_pc_plus4 = id_valid ? (head_pc + XLEN'(4)) : '0;
    assign id_instr    = id_valid ? fifo_rdata.instr : '0;

    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (fifo_count <= CNT_W'(FIFO_DEPTH))
                else $error("fetch_stage: fifo count exceeds depth");
        end
    end

`ifdef FETCH_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            stat_fetched      <= '0;
            stat_redirects    <= '0;
            stat_stall_cycles <= '0;
        end else begin
            if (push && (stat_fetched != '1)) begin
                stat_fetched <= stat_fetched + 32'd1;
            end
            if (redirect_valid && (stat_redirects != '1)) begin
                stat_redirects <= stat_redirects + 32'd1;
            end
            if (id_valid && !id_ready && (stat_stall_cycles != '1)) begin
                stat_stall_cycles <= stat_stall_cycles + 32'd1;
            end
        end
    end
`endif

endmodule
